tick_timer: RTL and testbench

//  - Programmable countdown timer clocked by the slow enable level from the clock splitter.
//  - Converts each rising edge of tick_in into a single-cycle strobe and decrements a loaded count on each strobe.
//  - Pulses `expired` when the count reaches zero.
//  - Sits directly downstream of the splitter; feeds LED, status and timeout logic.

---
 rtl/marvin_timer_pkg.sv | 13 +
 rtl/rise_strobe.sv | 24 ++
 rtl/tick_timer.sv | 112 +++++++++++
 tb/tb_tick_timer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/marvin_timer_pkg.sv
// Shared types and defaults for the tick timer and other slow-tick consumers.
package marvin_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    EXPIRE = 2'd3
  } timer_state_e;

  localparam int TIMER_W_DEFAULT = 16;

endpackage

// File: rtl/rise_strobe.sv
// Two-flop register of a slow level and a one-cycle strobe on its rising edge.
module rise_strobe (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic stb
);

  logic q1;
  logic q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      q1 <= d;
      q2 <= q1;
    end
  end

  assign stb = q1 & ~q2;

endmodule

// File: rtl/tick_timer.sv
// Programmable down-counter advanced by rising edges of a slow tick level.
// Define MARVIN_TIMER_AUTORELOAD_EN to make the timer periodic (reload on expiry).
//
//  state  | meaning
//  IDLE   | stopped; waits for start with a non-zero count
//  RUN    | decrementing on each tick strobe
//  PAUSE  | count held, ticks ignored until start
//  EXPIRE | one-cycle expiry pulse, count is 0
module tick_timer
  import marvin_timer_pkg::*;
#(
  parameter int W = TIMER_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_in,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         start,
  input  logic         stop,
  output logic         busy,
  output logic         expired,
  output logic [W-1:0] cnt_out
);

  timer_state_e state;
  timer_state_e nxt_state;
  logic [W-1:0] cnt;
  logic [W-1:0] nxt_cnt;
  logic         tick_stb;

  rise_strobe u_rise_strobe (
    .clk (clk),
    .rst (rst),
    .d   (tick_in),
    .stb (tick_stb)
  );

`ifdef MARVIN_TIMER_AUTORELOAD_EN
  logic [W-1:0] reload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload <= '0;
    end else if (load) begin
      reload <= load_val;
    end
  end
`endif

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    if (load) begin
      nxt_cnt   = load_val;
      nxt_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!stop && start && (cnt != '0)) nxt_state = RUN;
        end
        RUN: begin
          // start while already running is a no-op and does not swallow the tick
          if (stop) begin
            nxt_state = PAUSE;
          end else if (tick_stb) begin
            if (cnt == W'(1)) begin
              nxt_cnt   = '0;
              nxt_state = EXPIRE;
            end else if (cnt != '0) begin
              nxt_cnt = cnt - W'(1);
            end
          end
        end
        PAUSE: begin
          if (!stop && start) nxt_state = RUN;
        end
        EXPIRE: begin
`ifdef MARVIN_TIMER_AUTORELOAD_EN
          if (reload != '0) begin
            nxt_cnt   = reload;
            nxt_state = RUN;
          end else begin
            nxt_state = IDLE;
          end
`else
          nxt_state = IDLE;
`endif
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  // outputs are registered decodes of the next state so they align with state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      busy    <= (nxt_state == RUN) || (nxt_state == PAUSE);
      expired <= (nxt_state == EXPIRE);
    end
  end

  assign cnt_out = cnt;

endmodule

// File: tb/tb_tick_timer.sv
// Directed self-checking bench for tick_timer; follows MARVIN_TIMER_AUTORELOAD_EN.
module tb_tick_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_in;
  logic        load;
  logic [15:0] load_val;
  logic        start;
  logic        stop;
  logic        busy;
  logic        expired;
  logic [15:0] cnt_out;

  int n_checks = 0;
  int n_fail   = 0;
  int n_exp    = 0;

  tick_timer #(.W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_in  (tick_in),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .busy     (busy),
    .expired  (expired),
    .cnt_out  (cnt_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // count expiry pulses; busy must never be high alongside expired
  always @(negedge clk) begin
    if (expired === 1'b1) begin
      n_exp++;
      chk("busy_in_expire", busy, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_val = v;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic tick(input int hold);
    tick_in = 1'b1;
    repeat (hold) step();
    tick_in = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b1; tick_in = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0;
    repeat (2) step();
    chk("reset_cnt", cnt_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_expired", expired, 0);
    rst = 1'b0;
    step();

    // basic countdown with cycle-accurate first step
    do_load(16'd3);
    chk("load3_cnt", cnt_out, 3);
    chk("load3_busy", busy, 0);
    do_start();
    chk("start_busy", busy, 1);
    tick_in = 1'b1;
    step();
    chk("tick1_edge_k", cnt_out, 3);
    step();
    chk("tick1_edge_k1", cnt_out, 2);
    step(); step();
    tick_in = 1'b0;
    repeat (3) step();
    chk("level_one_dec", cnt_out, 2);
    tick(4);
    chk("tick2_cnt", cnt_out, 1);
    n_exp = 0;
    tick_in = 1'b1;
    step();
    chk("tick3_pre", cnt_out, 1);
    step();
    chk("tick3_cnt", cnt_out, 0);
    chk("tick3_expired", expired, 1);
    chk("tick3_busy", busy, 0);
    step();
    chk("post_expire_pulse", expired, 0);
`ifdef MARVIN_TIMER_AUTORELOAD_EN
    chk("post_expire_cnt", cnt_out, 3);
    chk("post_expire_busy", busy, 1);
`else
    chk("post_expire_cnt", cnt_out, 0);
    chk("post_expire_busy", busy, 0);
`endif
    step(); step();
    tick_in = 1'b0;
    repeat (3) step();
    chk("countdown_pulses", n_exp, 1);

    // async reset mid-run
    do_load(16'd5);
    do_start();
    chk("rst_pre_busy", busy, 1);
    n_exp = 0;
    rst = 1'b1;
    #1;
    chk("rst_async_cnt", cnt_out, 0);
    chk("rst_async_busy", busy, 0);
    step();
    rst = 1'b0;
    chk("rst_cnt", cnt_out, 0);
    chk("rst_expired", expired, 0);
    step();
    do_start();
    chk("rst_idle_start", busy, 0);
    chk("rst_no_pulse", n_exp, 0);

    // stop coincident with a tick strobe
    do_load(16'd4);
    do_start();
    tick_in = 1'b1;
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("pause_cnt", cnt_out, 4);
    chk("pause_busy", busy, 1);
    tick_in = 1'b0;
    repeat (3) step();
    tick(2);
    tick(2);
    chk("pause_hold_cnt", cnt_out, 4);
    chk("pause_hold_busy", busy, 1);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    tick(2);
    chk("pause_start_stop", cnt_out, 4);
    do_start();
    tick(2);
    chk("resume_cnt", cnt_out, 3);

    // load beats start and tick
    tick_in = 1'b1;
    step();
    load = 1'b1; load_val = 16'd9; start = 1'b1;
    step();
    load = 1'b0; start = 1'b0;
    chk("prio_cnt", cnt_out, 9);
    chk("prio_busy", busy, 0);
    step();
    chk("prio_idle_cnt", cnt_out, 9);
    chk("prio_idle_busy", busy, 0);
    tick_in = 1'b0;
    repeat (3) step();
    do_load(16'd0);
    do_start();
    chk("start_zero_busy", busy, 0);
    chk("start_zero_cnt", cnt_out, 0);

    // long level and single-cycle pulse
    do_load(16'd5);
    do_start();
    tick(20);
    chk("long_level", cnt_out, 4);
    tick(1);
    chk("short_pulse", cnt_out, 3);

    // periodic behaviour (or one-shot when reload is disabled)
    do_load(16'd2);
    do_start();
    n_exp = 0;
    for (int i = 0; i < 6; i++) tick(2);
`ifdef MARVIN_TIMER_AUTORELOAD_EN
    chk("reload_pulses", n_exp, 3);
    chk("reload_cnt", cnt_out, 2);
    chk("reload_busy", busy, 1);
`else
    chk("oneshot_pulses", n_exp, 1);
    chk("oneshot_cnt", cnt_out, 0);
    chk("oneshot_busy", busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
